// File: rtl/timing_control.sv
// timing_control: sequence counter driving the one-hot T bus plus a latched opcode decode on D.
// Define TC_STEP_EN to pause in a WAIT state after every instruction until a step pulse.
module timing_control #(
   parameter int SC_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   R,
   input  logic [2:0]             opcode,
   input  logic                   halt_req,
   input  logic                   step,
   output logic [(1<<SC_W)-1:0]   T,
   output logic [7:0]             D,
   output logic                   instr_done,
   output logic                   halted,
   output logic [CNT_W-1:0]       instr_count
);

   localparam int T_W = 1 << SC_W;

   typedef enum logic [1:0] {S_RUN, S_HALT, S_WAIT} state_t;

   state_t           state_q, state_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic [2:0]       op_q, op_d;
   logic             d_en_q, d_en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_last;

   // Final T-step of each opcode class.
   function automatic logic [SC_W-1:0] last_step(input logic [2:0] op);
      case (op)
         3'd5:    last_step = SC_W'(3);
         3'd6:    last_step = SC_W'(5);
         3'd7:    last_step = SC_W'(11);
         default: last_step = SC_W'(4);
      endcase
   endfunction

   assign is_last = (state_q == S_RUN) && d_en_q && (sc_q == last_step(op_q));

`ifndef TC_STEP_EN
   logic unused_step;
   assign unused_step = step;
`endif

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      op_d    = op_q;
      d_en_d  = d_en_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_RUN: begin
            if (is_last) begin
               sc_d   = '0;
               d_en_d = 1'b0;
               cnt_d  = cnt_q + CNT_W'(1);
               if (halt_req)
                  state_d = S_HALT;
`ifdef TC_STEP_EN
               else
                  state_d = S_WAIT;
`endif
            end else if (sc_q == '1) begin
               // Runaway guard: wrap to fetch without retiring anything.
               sc_d   = '0;
               d_en_d = 1'b0;
            end else begin
               sc_d = sc_q + SC_W'(1);
               if (sc_q == SC_W'(2)) begin
                  op_d   = opcode;
                  d_en_d = 1'b1;
               end
            end
         end
         S_HALT: begin
            if (!halt_req) begin
               state_d = S_RUN;
               sc_d    = '0;
            end
         end
`ifdef TC_STEP_EN
         S_WAIT: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (step) begin
               state_d = S_RUN;
               sc_d    = '0;
            end
         end
`endif
         default: begin
            state_d = S_RUN;
            sc_d    = '0;
            d_en_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (R) begin
         state_q <= S_RUN;
         sc_q    <= '0;
         op_q    <= 3'd0;
         d_en_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         op_q    <= op_d;
         d_en_q  <= d_en_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only; T parks at T0 outside RUN.
   assign T           = (state_q == S_RUN) ? (T_W'(1) << sc_q) : T_W'(1);
   assign D           = ((state_q == S_RUN) && d_en_q) ? (8'(1) << op_q) : 8'h00;
   assign instr_done  = is_last;
   assign halted      = (state_q == S_HALT);
   assign instr_count = cnt_q;

endmodule
